ui_burst_rd: RTL and testbench

UI_BURST_RD -- requirements
Module: ui_burst_rd

---
 rtl/ui_pkg.sv | 25 ++
 rtl/ui_hex_nibble.sv | 12 +
 rtl/ui_burst_rd.sv | 197 +++++++++++++++++++
 tb/tb_ui_burst_rd.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ui_pkg.sv
// Shared types and constants for the burst-read-to-ASCII dumper.
package ui_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HEX,
    ST_SEP,
    ST_CR,
    ST_LF,
    ST_DONE
  } state_t;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] DASH  = 8'h2D;

  // Hex digits needed to print a word of the given bit width.
  function automatic int nibble_count(input int width);
    return (width + 3) / 4;
  endfunction

endpackage

// File: rtl/ui_hex_nibble.sv
// Combinational 4-bit value to uppercase ASCII hex digit.
module ui_hex_nibble (
  input  logic [3:0] nib,
  output logic [7:0] chr
);

  always_comb begin
    if (nib < 4'd10) chr = 8'h30 + {4'h0, nib};
    else             chr = 8'h37 + {4'h0, nib};
  end

endmodule

// File: rtl/ui_burst_rd.sv
// Reads a burst of words from one of NCH memory channels and prints them as
// space-separated hex terminated by CR LF into a character FIFO.
module ui_burst_rd
  import ui_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int ADDRWIDTH = 10,
  parameter int DWIDTH    = 18,
  parameter int LENWIDTH  = 8,
  parameter int TIMEOUT   = 255,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_val,
  output logic                    cmd_rdy,
  input  logic [CHW-1:0]          cmd_chan,
  input  logic [ADDRWIDTH-1:0]    cmd_addr,
  input  logic [LENWIDTH-1:0]     cmd_len,
  output logic [NCH-1:0]          mem_rd,
  output logic [ADDRWIDTH-1:0]    mem_addr,
  input  logic [NCH-1:0]          mem_rdy,
  input  logic [NCH*DWIDTH-1:0]   mem_rdata,
  input  logic                    char_fifo_full,
  output logic [7:0]              char_fifo_din,
  output logic                    char_fifo_wr_en,
  output logic                    done,
  output logic [7:0]              miss_cnt
);

  localparam int ND  = nibble_count(DWIDTH);
  localparam int DPW = ND * 4;
  localparam int NIW = (ND > 1) ? $clog2(ND) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [NIW-1:0] NIB_TOP  = NIW'(ND - 1);
  localparam logic [TW-1:0]  TMR_LAST = TW'(TIMEOUT - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t                 state, state_nxt;
  logic [CHW-1:0]         chan_q;
  logic [ADDRWIDTH-1:0]   addr_q;
  logic [LENWIDTH-1:0]    rem_q;
  logic [DPW-1:0]         data_q;
  logic [NIW-1:0]         nib_q;
  logic [TW-1:0]          tmr_q;
  logic                   miss_q;
  logic [7:0]             miss_cnt_q;

  logic                   rdy_sel;
  logic [DWIDTH-1:0]      rdata_sel;
  logic [NCH-1:0]         chan_hot;
  logic [3:0]             nib_val;
  logic [7:0]             hex_chr;
  logic                   timeout_hit;
  logic                   push;

  // Demultiplex the selected channel's handshake and data slice.
  always_comb begin
    rdy_sel   = 1'b0;
    rdata_sel = '0;
    chan_hot  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (chan_q == CHW'(k)) begin
        rdy_sel     = mem_rdy[k];
        rdata_sel   = mem_rdata[k*DWIDTH +: DWIDTH];
        chan_hot[k] = 1'b1;
      end
    end
  end

  assign nib_val     = 4'(data_q >> {nib_q, 2'b00});
  assign timeout_hit = (tmr_q == TMR_LAST);
  assign push        = char_fifo_wr_en;
  assign mem_addr    = addr_q;
  assign miss_cnt    = miss_cnt_q;

  ui_hex_nibble u_hex (
    .nib (nib_val),
    .chr (hex_chr)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    cmd_rdy         = 1'b0;
    mem_rd          = '0;
    char_fifo_wr_en = 1'b0;
    char_fifo_din   = 8'h00;
    done            = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_val) state_nxt = (cmd_len == '0) ? ST_CR : ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_rd    = chan_hot;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (rdy_sel || timeout_hit) state_nxt = ST_HEX;
      end
      ST_HEX: begin
        char_fifo_din   = miss_q ? DASH : hex_chr;
        char_fifo_wr_en = !char_fifo_full;
        if (!char_fifo_full && nib_q == '0)
          state_nxt = (rem_q != LENWIDTH'(1)) ? ST_SEP : ST_CR;
      end
      ST_SEP: begin
        char_fifo_din   = SPACE;
        char_fifo_wr_en = !char_fifo_full;
        if (!char_fifo_full) state_nxt = ST_ISSUE;
      end
      ST_CR: begin
        char_fifo_din   = CR;
        char_fifo_wr_en = !char_fifo_full;
        if (!char_fifo_full) state_nxt = ST_LF;
      end
      ST_LF: begin
        char_fifo_din   = LF;
        char_fifo_wr_en = !char_fifo_full;
        if (!char_fifo_full) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control: address, digit index, rdy timer, miss tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      nib_q      <= '0;
      tmr_q      <= '0;
      miss_q     <= 1'b0;
      miss_cnt_q <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_val) addr_q <= cmd_addr;
        end
        ST_ISSUE: begin
          tmr_q  <= '0;
          miss_q <= 1'b0;
        end
        ST_WAIT: begin
          if (rdy_sel) begin
            nib_q  <= NIB_TOP;
            miss_q <= 1'b0;
          end else if (timeout_hit) begin
            nib_q      <= NIB_TOP;
            miss_q     <= 1'b1;
            miss_cnt_q <= sat_inc8(miss_cnt_q);
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        ST_HEX: begin
          if (push && nib_q != '0) nib_q <= nib_q - NIW'(1);
        end
        ST_SEP: begin
          if (push) addr_q <= addr_q + ADDRWIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Data: command fields and the captured word carry no reset.
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: begin
        if (cmd_val) begin
          chan_q <= cmd_chan;
          rem_q  <= cmd_len;
        end
      end
      ST_WAIT: begin
        if (rdy_sel) data_q <= DPW'(rdata_sel);
      end
      ST_SEP: begin
        if (push) rem_q <= rem_q - LENWIDTH'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ui_burst_rd.sv
// Self-checking bench for ui_burst_rd: table of bursts plus reset and saturation sequences.
module tb_ui_burst_rd;

  localparam int NCH = 2;
  localparam int AW  = 10;
  localparam int DW  = 18;
  localparam int LW  = 8;
  localparam int TO  = 4;
  localparam int NV  = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_val;
  logic                cmd_rdy;
  logic [0:0]          cmd_chan;
  logic [AW-1:0]       cmd_addr;
  logic [LW-1:0]       cmd_len;
  logic [NCH-1:0]      mem_rd;
  logic [AW-1:0]       mem_addr;
  logic [NCH-1:0]      mem_rdy;
  logic [NCH*DW-1:0]   mem_rdata;
  logic                char_fifo_full;
  logic [7:0]          char_fifo_din;
  logic                char_fifo_wr_en;
  logic                done;
  logic [7:0]          miss_cnt;

  always #5 clk = ~clk;

  ui_burst_rd #(
    .NCH(NCH), .ADDRWIDTH(AW), .DWIDTH(DW), .LENWIDTH(LW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_chan(cmd_chan),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .char_fifo_full(char_fifo_full), .char_fifo_din(char_fifo_din),
    .char_fifo_wr_en(char_fifo_wr_en), .done(done), .miss_cnt(miss_cnt)
  );

  typedef struct packed {
    logic                chan;
    logic [AW-1:0]       addr;
    logic [LW-1:0]       len;
    logic [3:0][DW-1:0]  data;
    logic [3:0]          miss;
    logic [3:0]          dly;
    logic                early;
    logic                stall;
    logic [7:0]          exp_miss;
  } rec_t;

  rec_t        tab [NV];
  string       exs [NV];
  string       crlf;
  logic [7:0]  char_q [$];
  logic [7:0]  mon_exp;
  int          nvec = 0;
  int          nfail = 0;
  int          strobe_cnt = 0;
  int          done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic rec_t mk(input logic ch, input logic [AW-1:0] a, input logic [LW-1:0] l,
                              input logic [3:0][DW-1:0] d, input logic [3:0] m,
                              input logic [3:0] dl, input logic e, input logic s,
                              input logic [7:0] em);
    rec_t r;
    r.chan = ch; r.addr = a; r.len = l; r.data = d; r.miss = m;
    r.dly = dl; r.early = e; r.stall = s; r.exp_miss = em;
    return r;
  endfunction

  // Character scoreboard and event counters.
  always @(negedge clk) begin
    #2;
    if (|mem_rd) strobe_cnt++;
    if (done) done_cnt++;
    if (char_fifo_wr_en) begin
      chk("push_when_full", 32'(char_fifo_full), 32'(0));
      chk("push_with_rd", 32'(mem_rd), 32'(0));
      if (char_q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL extra_char: got %02h, none expected (t=%0t)", char_fifo_din, $time);
      end else begin
        mon_exp = char_q.pop_front();
        chk("char", 32'(char_fifo_din), 32'(mon_exp));
      end
    end
  end

  task automatic burst(input rec_t r, input string es);
    int c, n, sc0, dc0;
    logic [AW-1:0] ea;
    sc0 = strobe_cnt;
    dc0 = done_cnt;
    for (int k = 0; k < es.len(); k++) char_q.push_back(es[k]);
    step();
    chk("idle_rdy", 32'(cmd_rdy), 32'(1));
    cmd_val = 1'b1; cmd_chan = r.chan; cmd_addr = r.addr; cmd_len = r.len;
    step();
    if (r.len == '0) cmd_val = 1'b0;
    else begin
      cmd_chan = ~r.chan; cmd_addr = ~r.addr; cmd_len = '1;
    end
    ea = r.addr;
    for (int i = 0; i < int'(r.len); i++) begin
      c = 0;
      while (mem_rd == '0 && c < 40) begin
        step();
        c++;
      end
      if (c >= 40) begin
        nvec++;
        nfail++;
        $display("FAIL strobe_timeout: got no mem_rd, expected word %0d", i);
        return;
      end
      if (i == 0) chk("acc_to_rd", 32'(c), 32'(0));
      chk("rd_onehot", 32'(mem_rd), 32'(1) << r.chan);
      chk("rd_addr", 32'(mem_addr), 32'(ea));
      chk("rd_no_wr", 32'(char_fifo_wr_en), 32'(0));
      if (r.early) begin
        mem_rdy[r.chan] = 1'b1;
        mem_rdata = {2{18'h15A5A}};
      end
      if (r.miss[i[1:0]]) begin
        n = 0;
        do begin
          step();
          cmd_val = 1'b0;
          mem_rdy = '0;
          n++;
        end while (!char_fifo_wr_en && n < 20);
        chk("miss_wait", 32'(n), 32'(TO + 1));
      end else begin
        step();
        cmd_val = 1'b0;
        mem_rdy = '0;
        for (int d = 1; d < int'(r.dly); d++) begin
          if (r.early) begin
            mem_rdy[~r.chan] = 1'b1;
            mem_rdata = {2{18'h15A5A}};
          end
          step();
          mem_rdy = '0;
        end
        mem_rdata = {2{18'h15A5A}};
        mem_rdata[int'(r.chan)*DW +: DW] = r.data[i[1:0]];
        mem_rdy[r.chan] = 1'b1;
        step();
        mem_rdy = '0;
        mem_rdata = '0;
        chk("rdy_to_char", 32'(char_fifo_wr_en), 32'(1));
        if (r.stall) begin
          step();
          char_fifo_full = 1'b1;
          for (int k = 0; k < 9; k++) begin
            step();
            chk("full_hold", 32'(char_fifo_wr_en), 32'(0));
          end
          char_fifo_full = 1'b0;
        end
      end
      ea = ea + 1'b1;
    end
    n = 0;
    while (!done && n < 200) begin
      step();
      n++;
    end
    chk("done_seen", 32'(done), 32'(1));
    step();
    chk("done_pulse", 32'(done), 32'(0));
    chk("rdy_after", 32'(cmd_rdy), 32'(1));
    chk("n_strobes", 32'(strobe_cnt - sc0), 32'(r.len));
    chk("n_done", 32'(done_cnt - dc0), 32'(1));
    chk("chars_left", 32'(char_q.size()), 32'(0));
    chk("miss_cnt", 32'(miss_cnt), 32'(r.exp_miss));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rec_t  rs;
    string s;
    crlf = "xx";
    crlf.putc(0, 8'h0D);
    crlf.putc(1, 8'h0A);

    tab[0] = mk(1'b1, 10'h005, 8'd2, {18'h0, 18'h0, 18'h00001, 18'h2ABCD}, 4'b0000, 4'd1, 1'b0, 1'b0, 8'd0);
    exs[0] = {"2ABCD 00001", crlf};
    tab[1] = mk(1'b0, 10'h3FF, 8'd2, {18'h0, 18'h0, 18'h3FFFF, 18'h12345}, 4'b0000, 4'd3, 1'b1, 1'b0, 8'd0);
    exs[1] = {"12345 3FFFF", crlf};
    tab[2] = mk(1'b1, 10'h010, 8'd1, '0, 4'b0001, 4'd1, 1'b0, 1'b0, 8'd1);
    exs[2] = {"-----", crlf};
    tab[3] = mk(1'b0, 10'h020, 8'd3, {18'h0, 18'h00A5B, 18'h389AB, 18'h0F0F0}, 4'b0000, 4'd2, 1'b0, 1'b1, 8'd1);
    exs[3] = {"0F0F0 389AB 00A5B", crlf};
    tab[4] = mk(1'b1, 10'h040, 8'd0, '0, 4'b0000, 4'd1, 1'b0, 1'b0, 8'd1);
    exs[4] = crlf;
    tab[5] = mk(1'b1, 10'h007, 8'd2, {18'h0, 18'h0, 18'h0, 18'h3C0DE}, 4'b0010, 4'd4, 1'b0, 1'b0, 8'd2);
    exs[5] = {"3C0DE -----", crlf};

    rst = 1'b1;
    cmd_val = 1'b0; cmd_chan = '0; cmd_addr = '0; cmd_len = '0;
    mem_rdy = '0; mem_rdata = '0; char_fifo_full = 1'b0;
    repeat (3) step();
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'(1));
    chk("rst_mem_rd", 32'(mem_rd), 32'(0));
    chk("rst_wr_en", 32'(char_fifo_wr_en), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_miss", 32'(miss_cnt), 32'(0));
    chk("rst_addr", 32'(mem_addr), 32'(0));
    chk("rst_din", 32'(char_fifo_din), 32'(0));
    rst = 1'b0;

    for (int v = 0; v < NV; v++) burst(tab[v], exs[v]);

    // Reset while waiting for rdy; a late rdy must be ignored.
    step();
    cmd_val = 1'b1; cmd_chan = 1'b0; cmd_addr = 10'h055; cmd_len = 8'd2;
    step();
    cmd_val = 1'b0;
    chk("rstw_rd", 32'(mem_rd), 32'(1));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstw_cmd_rdy", 32'(cmd_rdy), 32'(1));
    chk("rstw_mem_rd", 32'(mem_rd), 32'(0));
    chk("rstw_addr", 32'(mem_addr), 32'(0));
    chk("rstw_miss", 32'(miss_cnt), 32'(0));
    chk("rstw_wr_en", 32'(char_fifo_wr_en), 32'(0));
    mem_rdy = 2'b01;
    mem_rdata = {18'h0, 18'h2ABCD};
    for (int k = 0; k < 3; k++) begin
      step();
      chk("late_rdy_rd", 32'(mem_rd), 32'(0));
      chk("late_rdy_wr", 32'(char_fifo_wr_en), 32'(0));
    end
    mem_rdy = '0;
    mem_rdata = '0;
    burst(tab[0], exs[0]);

    // Long all-miss burst up to 255, then one more miss to show saturation.
    rs = mk(1'b1, 10'h3F0, 8'd255, '0, 4'b1111, 4'd1, 1'b0, 1'b0, 8'd255);
    s = "";
    for (int k = 0; k < 255; k++) s = {s, (k < 254) ? "----- " : "-----"};
    burst(rs, {s, crlf});
    rs = mk(1'b0, 10'h000, 8'd1, '0, 4'b1111, 4'd1, 1'b0, 1'b0, 8'd255);
    burst(rs, {"-----", crlf});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
